// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and address helper for the CNN window feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cnn_pkg;

  localparam int IMG_W = 28;                    // image width in pixels
  localparam int IMG_H = 28;                    // image height in pixels
  localparam int K     = 5;                     // kernel size, window is K x K
  localparam int PW    = 8;                     // pixel width in bits
  localparam int OUT_W = IMG_W - K + 1;         // window origins per row (24)
  localparam int OUT_H = IMG_H - K + 1;         // window origins per column (24)
  localparam int NPOS  = OUT_W * OUT_H;         // windows per frame (576)
  localparam int NPIX  = IMG_W * IMG_H;         // pixels per frame (784)
  localparam int AW    = $clog2(NPIX);          // frame memory address width
  localparam int CW    = $clog2(IMG_W);         // row/column coordinate width
  localparam int KW    = $clog2(K);             // column-within-window counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PRIME,
    ST_PRESENT,
    ST_SHIFT,
    ST_FIN
  } state_t;

  // Row-major address of img[row + i][col].
  function automatic logic [AW-1:0] seg_addr(input logic [CW-1:0] row,
                                             input logic [CW-1:0] col,
                                             input int i);
    return AW'((int'(row) + i) * IMG_W + int'(col));
  endfunction

endpackage

// File: rtl/cnn_window_feeder_if.sv
// Host-side bus of the window feeder: pixel load stream, window stream, status.
// Latency: n/a (wiring only).
// Backpressure: pixel side valid/ready, window side valid/ready.
interface cnn_window_feeder_if;
  import cnn_pkg::*;

  logic                 start;
  logic                 pix_valid;
  logic [PW-1:0]        pix_data;
  logic                 pix_ready;
  logic                 win_valid;
  logic                 win_ready;
  logic [CW-1:0]        x;
  logic [CW-1:0]        y;
  logic [K*K*PW-1:0]    imgin;
  logic                 busy;
  logic                 done;

  // Host: supplies pixels and consumes windows.
  modport master (
    output start, pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, x, y, imgin, busy, done
  );

  // Feeder: accepts pixels and produces windows.
  modport slave (
    input  start, pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, x, y, imgin, busy, done
  );

endinterface

// File: rtl/img_frame_ram.sv
// One-frame pixel store: one synchronous write port, K combinational reads down a column.
// Latency: write lands on the clock edge; reads are same-cycle combinational.
// Backpressure: none, the caller gates the write enable.
module img_frame_ram
  import cnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [PW-1:0]         wdata,
  input  logic [CW-1:0]         row,
  input  logic [CW-1:0]         col,
  output logic [K-1:0][PW-1:0]  rd
);

  // Contents are deliberately not reset; a frame is always reloaded before use.
  logic [PW-1:0] mem [NPIX];

  // Pixel write during LOAD.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Column segment img[row .. row+K-1][col], one read port per window row.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      rd[i] = mem[seg_addr(row, col, i)];
    end
  end

endmodule

// File: rtl/cnn_window_feeder.sv
// Buffers one image, then streams every KxK window with its X/Y origin.
// Latency: first window K cycles after the last pixel; 1 window per 2 cycles within a row.
// Backpressure: PIX_READY high for all of LOAD; window, X and Y hold while WIN_READY is low.
module cnn_window_feeder
  import cnn_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  cnn_window_feeder_if.slave bus
);

  state_t                       state;
  logic [AW-1:0]                pix_cnt;
  logic [KW-1:0]                prime_cnt;
  logic [CW-1:0]                x;
  logic [CW-1:0]                y;
  logic [K-1:0][K-1:0][PW-1:0]  win;        // win[i][j] = img[y+i][x+j]
  logic                         pix_ready;
  logic                         win_valid;
  logic                         busy;
  logic                         done;

  logic                         we;
  logic [CW-1:0]                rd_col;
  logic [K-1:0][PW-1:0]         rd;

  // pix_ready is high exactly in LOAD, so pixels outside LOAD never reach memory.
  assign we = pix_ready & bus.pix_valid;

  // PRIME fills window column prime_cnt; SHIFT fetches the column just right of the window.
  always_comb begin
    rd_col = x + CW'(prime_cnt);
    if (state == ST_SHIFT) begin
      rd_col = x + CW'(K);
    end
  end

  img_frame_ram u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (pix_cnt),
    .wdata (bus.pix_data),
    .row   (y),
    .col   (rd_col),
    .rd    (rd)
  );

  // Frame FSM with registered status/handshake outputs and the window shift register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      pix_cnt   <= '0;
      prime_cnt <= '0;
      x         <= '0;
      y         <= '0;
      win       <= '0;
      pix_ready <= 1'b0;
      win_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state     <= ST_LOAD;
            pix_cnt   <= '0;
            x         <= '0;
            y         <= '0;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (bus.pix_valid) begin
            pix_cnt <= pix_cnt + AW'(1);
            if (pix_cnt == AW'(NPIX - 1)) begin
              state     <= ST_PRIME;
              prime_cnt <= '0;
              pix_ready <= 1'b0;
            end
          end
        end

        ST_PRIME: begin
          for (int i = 0; i < K; i++) begin
            win[i][prime_cnt] <= rd[i];
          end
          prime_cnt <= prime_cnt + KW'(1);
          if (prime_cnt == KW'(K - 1)) begin
            state     <= ST_PRESENT;
            win_valid <= 1'b1;
          end
        end

        ST_PRESENT: begin
          if (bus.win_ready) begin
            win_valid <= 1'b0;
            if (x < CW'(OUT_W - 1)) begin
              state <= ST_SHIFT;
            end else if (y < CW'(OUT_H - 1)) begin
              state     <= ST_PRIME;
              prime_cnt <= '0;
              x         <= '0;
              y         <= y + CW'(1);
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
            end
          end
        end

        ST_SHIFT: begin
          for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
              win[i][j] <= win[i][j+1];
            end
            win[i][K-1] <= rd[i];
          end
          x         <= x + CW'(1);
          state     <= ST_PRESENT;
          win_valid <= 1'b1;
        end

        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          pix_ready <= 1'b0;
          win_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_ready = pix_ready;
  assign bus.win_valid = win_valid;
  assign bus.x         = x;
  assign bus.y         = y;
  assign bus.imgin     = win;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Scoreboard bench for cnn_window_feeder: expected windows queued at load, popped per handshake.
// Latency: n/a.
// Backpressure: random WIN_READY stalls in selected runs.
module tb_cnn_window_feeder;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cnn_window_feeder_if bus();

  cnn_window_feeder dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [CW-1:0]     x;
    logic [CW-1:0]     y;
    logic [K*K*PW-1:0] w;
  } win_t;

  win_t          sb_q[$];
  logic [PW-1:0] img [IMG_H][IMG_W];

  int checks    = 0;
  int failures  = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int gap_cnt   = 0;
  bit mon_en    = 1'b0;
  bit stall_mode = 1'b0;
  bit ramp_chk  = 1'b0;
  bit gap_track = 1'b0;
  bit gap_arm   = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [K*K*PW-1:0] exp_win(input int x, input int y);
    logic [K*K*PW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*PW +: PW] = img[y+i][x+j];
    return w;
  endfunction

  task automatic fill_img(input bit rnd);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = rnd ? PW'($urandom_range(0, 255)) : PW'((r*IMG_W + c) % 256);
  endtask

  task automatic push_all();
    win_t e;
    sb_q.delete();
    for (int y = 0; y < OUT_H; y++)
      for (int x = 0; x < OUT_W; x++) begin
        e.x = CW'(x);
        e.y = CW'(y);
        e.w = exp_win(x, y);
        sb_q.push_back(e);
      end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_pix_ready"}, bus.pix_ready, 0);
    chk({pfx, "_win_valid"}, bus.win_valid, 0);
    chk({pfx, "_x"},         bus.x, 0);
    chk({pfx, "_y"},         bus.y, 0);
    chk({pfx, "_imgin"},     bus.imgin, 0);
    chk({pfx, "_busy"},      bus.busy, 0);
    chk({pfx, "_done"},      bus.done, 0);
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_pix_ready", bus.pix_ready, 1);
    chk("start_busy", bus.busy, 1);
  endtask

  task automatic load_pixels(input int n);
    for (int p = 0; p < n; p++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = img[p / IMG_W][p % IMG_W];
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.win_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!bus.done && n < 9000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // WIN_READY driver: always ready, or a fair coin per cycle in stall runs.
  initial begin
    bus.win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.win_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Window monitor: handshakes pop the scoreboard; stalled cycles must still show the queue head.
  always @(negedge clk) begin
    win_t e;
    if (mon_en) begin
      if (bus.done) done_cnt++;
      if (bus.win_valid) begin
        if (gap_arm) begin
          chk("row_gap_cycles", gap_cnt, 5);
          chk("row_next_b0", bus.imgin[7:0], 28);
          gap_arm = 1'b0;
        end
        if (sb_q.size() == 0) begin
          chk("extra_window", bus.win_valid, 0);
        end else begin
          e = sb_q[0];
          if (bus.win_ready) begin
            chk("win", {bus.x, bus.y, bus.imgin}, {e.x, e.y, e.w});
            void'(sb_q.pop_front());
            hs_cnt++;
            if (gap_track && e.x == CW'(OUT_W-1) && e.y == 0) begin
              gap_arm   = 1'b1;
              gap_cnt   = 0;
              gap_track = 1'b0;
            end
            if (ramp_chk && e.x == CW'(OUT_W-1) && e.y == CW'(OUT_H-1)) begin
              chk("last_b0", bus.imgin[7:0], 155);
              chk("last_b24", bus.imgin[199:192], 15);
            end
          end else begin
            chk("stall_hold", {bus.x, bus.y, bus.imgin}, {e.x, e.y, e.w});
          end
        end
      end else if (gap_arm) begin
        gap_cnt++;
      end
    end
  end

  initial begin
    #(800000);
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nn;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1: ramp image, always ready; latency, first/last window, row gap, frame length.
    fill_img(1'b0);
    push_all();
    hs_cnt = 0; done_cnt = 0;
    stall_mode = 1'b0; ramp_chk = 1'b1; gap_track = 1'b1; mon_en = 1'b1;
    start_frame();
    load_pixels(NPIX);
    chk("prime_no_pix_ready", bus.pix_ready, 0);
    wait_valid(n);
    chk("first_latency", n, 5);
    chk("first_x", bus.x, 0);
    chk("first_y", bus.y, 0);
    chk("first_b0", bus.imgin[7:0], 0);
    chk("first_b4", bus.imgin[39:32], 4);
    chk("first_b5", bus.imgin[47:40], 28);
    chk("first_b24", bus.imgin[199:192], 116);
    wait_done(n, nn);
    chk("frame_cycles", nn, 1248);
    chk("busy_with_done", bus.busy, 1);
    @(posedge clk); #1;
    chk("done_fall", bus.done, 0);
    chk("busy_fall", bus.busy, 0);
    chk("hs_count", hs_cnt, NPOS);
    chk("queue_drained", sb_q.size(), 0);
    chk("done_pulses", done_cnt, 1);

    // Run 2: same image with random stalls; START and PIX_VALID poked mid-stream.
    push_all();
    hs_cnt = 0; done_cnt = 0;
    stall_mode = 1'b1; gap_track = 1'b0;
    start_frame();
    load_pixels(NPIX);
    wait_valid(n);
    chk("stall_first_latency", n, 5);
    repeat (30) begin @(posedge clk); #1; end
    bus.start     = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data  = '1;
    repeat (6) begin @(posedge clk); #1; end
    chk("poke_pix_ready", bus.pix_ready, 0);
    chk("poke_busy", bus.busy, 1);
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    wait_done(0, nn);
    chk("stall_done_seen", bus.done, 1);
    @(posedge clk); #1;
    chk("stall_hs_count", hs_cnt, NPOS);
    chk("stall_done_pulses", done_cnt, 1);
    chk("stall_busy_fall", bus.busy, 0);

    // Run 3: reset in the middle of LOAD.
    mon_en = 1'b0; stall_mode = 1'b0; ramp_chk = 1'b0;
    start_frame();
    load_pixels(400);
    rst_n = 1'b0;
    #1;
    check_reset("rst_load");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 4: reset in the middle of PRESENT.
    fill_img(1'b1);
    push_all();
    hs_cnt = 0; mon_en = 1'b1;
    start_frame();
    load_pixels(NPIX);
    n = 0;
    while (hs_cnt < 30 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_hs", hs_cnt, 30);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset("rst_present");
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 5: fresh image and full reload after reset.
    fill_img(1'b1);
    push_all();
    hs_cnt = 0; done_cnt = 0; mon_en = 1'b1;
    start_frame();
    load_pixels(NPIX);
    wait_valid(n);
    chk("reload_latency", n, 5);
    chk("reload_first_win", bus.imgin, exp_win(0, 0));
    wait_done(n, nn);
    chk("reload_frame_cycles", nn, 1248);
    @(posedge clk); #1;
    chk("reload_hs_count", hs_cnt, NPOS);
    chk("reload_done_pulses", done_cnt, 1);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
